// File: rtl/sys_pkg.sv
// Sizing shared by the A/B operand buffer, the input FIFO and the array edge logic.
package sys_pkg;

    localparam int AB_DW         = 16;
    localparam int AB_FIFO_DEPTH = 8;
    localparam int AB_FF_MARGIN  = 2;
    localparam int AB_FIFO_AW    = $clog2(AB_FIFO_DEPTH);

    typedef logic [AB_DW-1:0] ab_word_t;

endpackage

// File: rtl/fifo_ctl.sv
// Pointer, occupancy and flag control for the A/B input FIFO.
module fifo_ctl
    import sys_pkg::*;
#(
    parameter int DEPTH     = AB_FIFO_DEPTH,
    parameter int AW        = AB_FIFO_AW,
    parameter int FF_MARGIN = AB_FF_MARGIN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          we,
    input  logic          rd,
    output logic          wr_ok,
    output logic          pop_ok,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   count,
    output logic          ff,
    output logic          empty,
    output logic          ovf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] FF_THR   = (AW+1)'(DEPTH - FF_MARGIN);

    assign empty  = (count == '0);
    assign ff     = (count >= FF_THR);

    // start masks both strobes so a clear cycle never touches storage or pointers.
    assign pop_ok = rd & ~start & ~empty;
    assign wr_ok  = we & ~start & ((count < FULL_CNT) | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (start) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ok)
                wptr <= wptr + AW'(1);
            if (pop_ok)
                rptr <= rptr + AW'(1);
            unique case ({wr_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (we && !wr_ok)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/ab_infifo.sv
// Elastic FIFO between the A/B operand buffer and the systolic array edge.
module ab_infifo
    import sys_pkg::*;
#(
    parameter int DW        = AB_DW,
    parameter int DEPTH     = AB_FIFO_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int FF_MARGIN = AB_FF_MARGIN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          we,
    input  logic [DW-1:0] ab_in,
    output logic          ff,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          dvalid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf
);

    logic          wr_ok;
    logic          pop_ok;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [DW-1:0] mem [DEPTH];

    fifo_ctl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .FF_MARGIN (FF_MARGIN)
    ) u_ctl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .we     (we),
        .rd     (rd),
        .wr_ok  (wr_ok),
        .pop_ok (pop_ok),
        .wptr   (wptr),
        .rptr   (rptr),
        .count  (count),
        .ff     (ff),
        .empty  (empty),
        .ovf    (ovf)
    );

    // Storage carries no reset; a full-FIFO read+write reads the old entry via NBA ordering.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= ab_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else if (start) begin
            dvalid <= 1'b0;
        end else begin
            dvalid <= pop_ok;
            if (pop_ok)
                dout <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_ab_infifo.sv
// Scoreboard bench for ab_infifo: accepted writes queue expected data, pops compare in order.
module tb_ab_infifo;

    localparam int DW        = 16;
    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int FF_MARGIN = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          we;
    logic [DW-1:0] ab_in;
    logic          ff;
    logic          rd;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;

    always #5 clk = ~clk;

    ab_infifo #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .FF_MARGIN (FF_MARGIN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .we     (we),
        .ab_in  (ab_in),
        .ff     (ff),
        .rd     (rd),
        .dout   (dout),
        .dvalid (dvalid),
        .empty  (empty),
        .count  (count),
        .ovf    (ovf)
    );

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] sb_q [$];
    int            mcnt = 0;
    logic          movf = 1'b0;
    logic [DW-1:0] nd;
    logic [DW-1:0] held;
    logic          pw;
    logic          pnxt;
    logic          wv;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own state, then checks outputs.
    task automatic cycle(input logic s, input logic w, input logic r, input logic [DW-1:0] d);
        logic m_pop;
        logic m_wr;
        start = s;
        we    = w;
        rd    = r;
        ab_in = d;
        m_pop = 1'b0;
        m_wr  = 1'b0;
        if (s) begin
            sb_q.delete();
            mcnt = 0;
            movf = 1'b0;
        end else begin
            m_pop = r && (mcnt > 0);
            m_wr  = w && ((mcnt < DEPTH) || m_pop);
            if (m_wr)
                sb_q.push_back(d);
            if (w && !m_wr)
                movf = 1'b1;
            mcnt = mcnt + int'(m_wr) - int'(m_pop);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        we    = 1'b0;
        rd    = 1'b0;
        chk("dvalid", 32'(dvalid), 32'(m_pop));
        if (m_pop)
            chk("dout", 32'(dout), 32'(sb_q.pop_front()));
        chk("count", 32'(count), 32'(mcnt));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("ff", 32'(ff), 32'(mcnt >= DEPTH - FF_MARGIN));
        chk("ovf", 32'(ovf), 32'(movf));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        we    = 1'b0;
        rd    = 1'b0;
        ab_in = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ff", 32'(ff), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Fill to the almost-full threshold, then to full, then one dropped write.
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, DW'(i));
            if (i == 5) chk("ff_below", 32'(ff), 32'd0);
        end
        chk("ff_at6", 32'(ff), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 16'h0007);
        cycle(1'b0, 1'b1, 1'b0, 16'h0008);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ovf", 32'(ovf), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0009);
        chk("drop_ovf", 32'(ovf), 32'd1);
        chk("drop_count", 32'(count), 32'd8);

        // Drain with rd held for 9 cycles.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            if (i < 8) chk("drain_data", 32'(dout), 32'(i + 1));
            if (i == 7) chk("drain_empty", 32'(empty), 32'd1);
            if (i == 8) chk("drain_dv_end", 32'(dvalid), 32'd0);
        end

        // Streaming at constant occupancy across pointer wrap.
        nd = 16'h0100;
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b0, nd);
            nd++;
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, nd);
            nd++;
            chk("stream_count", 32'(count), 32'd3);
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b1, 16'h0AAA);
        chk("nobypass_dv", 32'(dvalid), 32'd0);
        chk("nobypass_cnt", 32'(count), 32'd1);
        repeat (2) cycle(1'b0, 1'b0, 1'b1, '0);

        // Registered-we producer against a stalled, then resuming, consumer.
        cycle(1'b1, 1'b0, 1'b0, '0);
        nd = 16'h2000;
        pw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            pnxt = ~ff;
            wv   = pw;
            cycle(1'b0, wv, (i >= 30), nd);
            if (wv) nd++;
            pw = pnxt;
            chk("prod_ovf", 32'(ovf), 32'd0);
        end
        repeat (12) cycle(1'b0, 1'b0, 1'b1, '0);
        chk("prod_drained", 32'(count), 32'd0);

        // start clears state mid-operation and ignores same-cycle strobes.
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, DW'(16'h3000 + i));
        repeat (3) cycle(1'b0, 1'b0, 1'b1, '0);
        chk("pre_start_cnt", 32'(count), 32'd5);
        chk("pre_start_ovf", 32'(ovf), 32'd1);
        held = dout;
        cycle(1'b1, 1'b1, 1'b1, 16'hBEEF);
        chk("start_count", 32'(count), 32'd0);
        chk("start_empty", 32'(empty), 32'd1);
        chk("start_ovf", 32'(ovf), 32'd0);
        chk("start_dvalid", 32'(dvalid), 32'd0);
        chk("start_dout_hold", 32'(dout), 32'(held));

        // Asynchronous reset asserted between clock edges.
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, DW'(16'h4000 + i));
        cycle(1'b0, 1'b0, 1'b1, '0);
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        mcnt = 0;
        movf = 1'b0;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ff", 32'(ff), 32'd0);
        chk("arst_dvalid", 32'(dvalid), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 16'h5555);
        cycle(1'b0, 1'b0, 1'b1, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
